gen_dec_pipe_top: RTL and testbench
===================================

# gen_dec_pipe_top

Pipelined, flow-controlled successor to the combinational one-hot decoder. Output width is any value ≥2, not only a power of two. It supports one-hot and thermometer encodings, flags out-of-range codes, and carries data through a valid/ready register slice with a one-entry skid buffer. It sits between a code producer, such as an arbiter index or an address field, and a consumer that may apply backpressure.

## Interface
Parameters:
- DAT_OUT_W, default 6: decoded output width [bits], ≥2.
- MODE, default 0: output encoding.
  - 0: one-hot, dat_out[i] = (code==i).
  - 1: thermometer, dat_out[i] = (i ≤ code).
- DAT_IN_W, localparam = $clog2(DAT_OUT_W): encoded input width [bits].

Ports:
- clk      in   1          clock; all logic is rising-edge.
- rst_n    in   1          asynchronous active-low reset.
- in_vld   in   1          input code valid.
- in_rdy   out  1          block can accept an input this cycle.
- dat_in   in   DAT_IN_W   encoded input.
- en       in   1          enable, sampled with dat_in; 0 gives all-zero output.
- out_vld  out  1          output word valid.
- out_rdy  in   1          consumer accepts the output word this cycle.
- dat_out  out  DAT_OUT_W  decoded word.
- out_err  out  1          the word came from an out-of-range code.

Reset is asynchronous and active-low. One clock domain.

## Operation
- An input is accepted on a rising edge with in_vld & in_rdy. An output is consumed on a rising edge with out_vld & out_rdy.
- Decode is computed from dat_in and en at acceptance:
  - en=0: word = 0, err = 0, regardless of dat_in.
  - en=1 and dat_in ≥ DAT_OUT_W (out of range, only possible when DAT_OUT_W is not a power of two): word = 0, err = 1.
  - en=1, in range, MODE 0: exactly bit dat_in set, err = 0.
  - en=1, in range, MODE 1: bits [dat_in:0] set, err = 0.
- Storage is a main register (drives the outputs) plus a skid register. There are three states:
  - EMPTY: main and skid both invalid.
  - ONE: main valid.
  - TWO: main and skid valid.
- State transitions (acc = accepted, pop = consumed):
  - EMPTY: acc → ONE, main gets the decoded input.
  - ONE: acc & !pop → TWO, skid gets the input. pop & !acc → EMPTY. acc & pop → ONE, main gets the input. Neither → hold.
  - TWO: pop → ONE, main gets skid. No accept is possible in TWO.
- in_rdy is a registered flag: 1 in EMPTY and ONE, 0 in TWO. It never depends combinationally on out_rdy or in_vld.
- Words leave in acceptance order. No word is dropped or duplicated.
- While out_vld=1 and out_rdy=0, dat_out and out_err hold stable.
- While out_vld=0, dat_out and out_err keep their last value. They are don't-care.
- A 1-bit dat_in (DAT_OUT_W=2) has no out-of-range codes, so out_err is always 0.

## Timing
- Reset values: state EMPTY, out_vld=0, in_rdy=1, dat_out=0, out_err=0, skid contents=0.
- Reset assertion mid-operation discards both registers on the spot (asynchronous). The first accept is possible on the first rising edge after rst_n deasserts.
- Latency: an input accepted at edge N appears with out_vld=1 after edge N.
- Throughput: one word per cycle sustained while out_rdy=1.
- Backpressure:
  - A single out_rdy=0 cycle with in_vld held high fills the skid. in_rdy drops the cycle after.
  - in_rdy returns to 1 the cycle after the pop that leaves TWO.
- Simultaneous accept and pop in ONE keeps the state at ONE with no bubble.
- No combinational path from any input to any output.

## Test plan
- Reset: rst_n=0 → out_vld=0, in_rdy=1, dat_out=0, out_err=0. Assert rst_n=0 while in TWO → outputs return to reset values immediately.
- Full-rate one-hot streaming (DAT_OUT_W=6, MODE=0, en=1, out_rdy=1): codes 0..5, one per cycle → dat_out 0x01,0x02,0x04,0x08,0x10,0x20 with 1-cycle latency, out_vld continuous, out_err=0.
- Out-of-range and enable (DAT_OUT_W=6):
  - en=1, codes 6 and 7 → dat_out=0, out_err=1.
  - en=0, code 3 → dat_out=0, out_err=0.
- Thermometer (DAT_OUT_W=6, MODE=1):
  - code 0 → 0x01.
  - code 3 → 0x0F.
  - code 5 → 0x3F.
  - code 7 → 0x00 with out_err=1.
- Backpressure: stream codes 1,2,3 with out_rdy=0 for 3 cycles → state reaches TWO, in_rdy=0, dat_out holds 0x02 (code 1) stable. Release out_rdy → words 0x02, 0x04, 0x08 emerge in order, nothing lost.
- Random stress: random in_vld/out_rdy/en/dat_in for 10k cycles against a scoreboard → order preserved, no loss or duplication, in_rdy=0 exactly when two words are held.

Source files
------------

// File: rtl/gen_dec_pipe_top.sv
// Parameterised one-hot/thermometer decoder behind a valid/ready slice with a one-entry skid.
// Latency 1 cycle; in_rdy is registered and drops only while both main and skid hold a word.
module gen_dec_pipe_top #(
  parameter int  DAT_OUT_W = 6,
  parameter int  MODE      = 0,
  localparam int DAT_IN_W  = $clog2(DAT_OUT_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [DAT_IN_W-1:0]  dat_in,
  input  logic                 en,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [DAT_OUT_W-1:0] dat_out,
  output logic                 out_err
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                 state;
  logic [DAT_OUT_W-1:0]   skid_dat;
  logic                   skid_err;
  logic [DAT_OUT_W-1:0]   dec_dat;
  logic                   dec_err;
  logic [31:0]            code;
  logic                   acc;
  logic                   pop;

  assign code = 32'(dat_in);
  assign acc  = in_vld & in_rdy;
  assign pop  = out_vld & out_rdy;

  // Codes past the top of a non-power-of-two width decode to zero and raise err.
  always_comb begin
    dec_dat = '0;
    dec_err = 1'b0;
    if (en) begin
      if (code >= 32'(DAT_OUT_W)) begin
        dec_err = 1'b1;
      end else begin
        for (int i = 0; i < DAT_OUT_W; i++) begin
          dec_dat[i] = (MODE == 0) ? (code == 32'(i)) : (32'(i) <= code);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_EMPTY;
      in_rdy   <= 1'b1;
      out_vld  <= 1'b0;
      dat_out  <= '0;
      out_err  <= 1'b0;
      skid_dat <= '0;
      skid_err <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (acc) begin
            dat_out <= dec_dat;
            out_err <= dec_err;
            out_vld <= 1'b1;
            state   <= S_ONE;
          end
        end
        S_ONE: begin
          if (acc && !pop) begin
            skid_dat <= dec_dat;
            skid_err <= dec_err;
            in_rdy   <= 1'b0;
            state    <= S_TWO;
          end else if (pop && !acc) begin
            out_vld <= 1'b0;
            state   <= S_EMPTY;
          end else if (acc && pop) begin
            dat_out <= dec_dat;
            out_err <= dec_err;
          end
        end
        S_TWO: begin
          // in_rdy is low here, so the only event is draining skid into main.
          if (pop) begin
            dat_out <= skid_dat;
            out_err <= skid_err;
            in_rdy  <= 1'b1;
            state   <= S_ONE;
          end
        end
        default: begin
          state   <= S_EMPTY;
          in_rdy  <= 1'b1;
          out_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gen_dec_pipe_top.sv
// Bench for gen_dec_pipe_top: one-hot W=6, thermometer W=6 and one-hot W=2 instances on shared handshakes,
// checked every cycle against a queue model plus hand-computed literal expectations.
module tb_gen_dec_pipe_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_vld;
  logic       out_rdy;
  logic       en;
  logic [2:0] dat_in;

  logic       rdy0, rdy1, rdy2;
  logic       vld0, vld1, vld2;
  logic [5:0] d0, d1;
  logic [1:0] d2;
  logic       e0, e1, e2;

  int passes = 0;
  int total  = 0;
  bit cmp_on = 1'b0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];

  always #5 clk = ~clk;

  gen_dec_pipe_top #(.DAT_OUT_W(6), .MODE(0)) u_oh (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(rdy0), .dat_in(dat_in), .en(en),
    .out_vld(vld0), .out_rdy(out_rdy), .dat_out(d0), .out_err(e0));

  gen_dec_pipe_top #(.DAT_OUT_W(6), .MODE(1)) u_th (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(rdy1), .dat_in(dat_in), .en(en),
    .out_vld(vld1), .out_rdy(out_rdy), .dat_out(d1), .out_err(e1));

  gen_dec_pipe_top #(.DAT_OUT_W(2), .MODE(0)) u_w2 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(rdy2), .dat_in(dat_in[0]), .en(en),
    .out_vld(vld2), .out_rdy(out_rdy), .dat_out(d2), .out_err(e2));

  // Expected {err, word} straight from the decode rules.
  function automatic logic [8:0] model_dec(input int mode, input int w, input logic e, input int c);
    if (!e) return 9'd0;
    if (c >= w) return 9'h100;
    if (mode == 0) return 9'(1 << c);
    return 9'((1 << (c + 1)) - 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Two-entry queue model: a word sits here from acceptance until consumption.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete(); q1.delete(); q2.delete();
    end else begin
      automatic bit acc = in_vld && (q0.size() < 2);
      automatic bit pop = (q0.size() > 0) && out_rdy;
      if (pop) begin
        void'(q0.pop_front()); void'(q1.pop_front()); void'(q2.pop_front());
      end
      if (acc) begin
        q0.push_back(model_dec(0, 6, en, int'(dat_in)));
        q1.push_back(model_dec(1, 6, en, int'(dat_in)));
        q2.push_back(model_dec(0, 2, en, int'(dat_in[0])));
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on && rst_n) begin
      chk("rdy_oh", 32'(rdy0), 32'(q0.size() < 2));
      chk("rdy_th", 32'(rdy1), 32'(q1.size() < 2));
      chk("rdy_w2", 32'(rdy2), 32'(q2.size() < 2));
      chk("vld_oh", 32'(vld0), 32'(q0.size() > 0));
      chk("vld_th", 32'(vld1), 32'(q1.size() > 0));
      chk("vld_w2", 32'(vld2), 32'(q2.size() > 0));
      if (q0.size() > 0) chk("word_oh", 32'({e0, 2'b00, d0}), 32'(q0[0]));
      if (q1.size() > 0) chk("word_th", 32'({e1, 2'b00, d1}), 32'(q1[0]));
      if (q2.size() > 0) chk("word_w2", 32'({e2, 6'b0, d2}), 32'(q2[0]));
    end
  end

  task automatic xfer(input logic v, input logic r, input logic e, input logic [2:0] c);
    in_vld  = v;
    out_rdy = r;
    en      = e;
    dat_in  = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [5:0] oh_tab[6] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};
  logic [5:0] th_tab[6] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F};

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; en = 1'b0; dat_in = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_vld", 32'(vld0), 32'd0);
    chk("rst_rdy", 32'(rdy0), 32'd1);
    chk("rst_dat", 32'(d0), 32'd0);
    chk("rst_err", 32'(e0), 32'd0);
    rst_n  = 1'b1;
    cmp_on = 1'b1;

    for (int k = 0; k < 6; k++) begin
      xfer(1'b1, 1'b1, 1'b1, 3'(k));
      chk("stream_oh", 32'(d0), 32'(oh_tab[k]));
      chk("stream_th", 32'(d1), 32'(th_tab[k]));
      chk("stream_vld", 32'(vld0), 32'd1);
      chk("stream_err", 32'(e0), 32'd0);
    end

    xfer(1'b1, 1'b1, 1'b1, 3'd6);
    chk("oor6_dat", 32'(d0), 32'd0);
    chk("oor6_err", 32'(e0), 32'd1);
    xfer(1'b1, 1'b1, 1'b1, 3'd7);
    chk("oor7_dat", 32'(d0), 32'd0);
    chk("oor7_err", 32'(e0), 32'd1);
    chk("w2_noerr", 32'(e2), 32'd0);
    xfer(1'b1, 1'b1, 1'b0, 3'd3);
    chk("en0_dat", 32'(d0), 32'd0);
    chk("en0_err", 32'(e0), 32'd0);

    xfer(1'b1, 1'b1, 1'b1, 3'd0);
    chk("th0", 32'(d1), 32'h01);
    xfer(1'b1, 1'b1, 1'b1, 3'd3);
    chk("th3", 32'(d1), 32'h0F);
    xfer(1'b1, 1'b1, 1'b1, 3'd5);
    chk("th5", 32'(d1), 32'h3F);
    xfer(1'b1, 1'b1, 1'b1, 3'd7);
    chk("th7_dat", 32'(d1), 32'h00);
    chk("th7_err", 32'(e1), 32'd1);
    xfer(1'b0, 1'b1, 1'b1, 3'd0);
    chk("drain_vld", 32'(vld0), 32'd0);

    xfer(1'b1, 1'b0, 1'b1, 3'd1);
    chk("bp1_dat", 32'(d0), 32'h02);
    chk("bp1_rdy", 32'(rdy0), 32'd1);
    xfer(1'b1, 1'b0, 1'b1, 3'd2);
    chk("bp2_dat", 32'(d0), 32'h02);
    chk("bp2_rdy", 32'(rdy0), 32'd0);
    xfer(1'b1, 1'b0, 1'b1, 3'd3);
    chk("bp3_dat", 32'(d0), 32'h02);
    chk("bp3_rdy", 32'(rdy0), 32'd0);
    xfer(1'b1, 1'b1, 1'b1, 3'd3);
    chk("rel1_dat", 32'(d0), 32'h04);
    chk("rel1_rdy", 32'(rdy0), 32'd1);
    xfer(1'b1, 1'b1, 1'b1, 3'd3);
    chk("rel2_dat", 32'(d0), 32'h08);
    xfer(1'b0, 1'b1, 1'b1, 3'd0);
    chk("rel3_vld", 32'(vld0), 32'd0);

    xfer(1'b1, 1'b0, 1'b1, 3'd4);
    xfer(1'b1, 1'b0, 1'b1, 3'd5);
    chk("two_rdy", 32'(rdy0), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(vld0), 32'd0);
    chk("arst_rdy", 32'(rdy0), 32'd1);
    chk("arst_dat", 32'(d0), 32'd0);
    chk("arst_th", 32'(d1), 32'd0);
    chk("arst_err", 32'(e0), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    xfer(1'b1, 1'b1, 1'b1, 3'd2);
    chk("post_rst_dat", 32'(d0), 32'h04);
    chk("post_rst_vld", 32'(vld0), 32'd1);

    for (int n = 0; n < 10000; n++) begin
      xfer(1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(7) != 0), 3'($urandom_range(7)));
    end

    in_vld = 1'b0; out_rdy = 1'b1;
    for (int n = 0; n < 5 && vld0; n++) @(negedge clk);
    chk("final_vld", 32'(vld0), 32'd0);
    chk("final_q", 32'(q0.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
